// File: rtl/spi_blink_ctrl.sv
// spi_blink_ctrl
// ----------------------------------------------------------------------------
// Command decoder and LED blink scheduler fed by the SPI slave receiver.
// Frames are one opcode byte followed by 0..4 big-endian payload bytes:
//   0x00 NOP, 0x01 SET_PERIOD (4 bytes), 0x02 SET_MODE (1 byte: bit0 enable,
//   bit1 invert), 0x03 BLINK_N (1 byte N, 2*N toggles, N=0 continuous),
//   0x04 CLR_ERR. Unknown opcodes set the sticky error flag.
//
// Optional feature: define SPI_BLINK_TIMEOUT_EN to abort a partial frame
// (and set err) after TIMEOUT_CYCLES idle cycles in the payload phase.
//
// Parameters:
//   DEF_HALF_PERIOD  reset half-period in clk cycles
//   TIMEOUT_CYCLES   inter-byte gap that aborts a partial frame
// Ports:
//   clk              system clock
//   rst_n            synchronous reset, active-low
//   o_spi_s_rx_done  received-byte strobe (one byte per high cycle)
//   r_spi_s_rx_data  received byte, valid with the strobe
//   led              LED drive (phase XOR invert)
//   led_en           LED pin enable, constant 1
//   clk_en           clock input enable, constant 1
//   busy             frame in progress (FSM not idle)
//   err              sticky error flag
//   half_period      active half-period register
// ----------------------------------------------------------------------------
module spi_blink_ctrl #(
    parameter int unsigned DEF_HALF_PERIOD = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        o_spi_s_rx_done,
    input  logic [7:0]  r_spi_s_rx_data,
    output logic        led,
    output logic        led_en,
    output logic        clk_en,
    output logic        busy,
    output logic        err,
    output logic [31:0] half_period
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_EXEC    = 2'd2;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_PERIOD = 8'h01;
    localparam logic [7:0] OP_SET_MODE   = 8'h02;
    localparam logic [7:0] OP_BLINK_N    = 8'h03;
    localparam logic [7:0] OP_CLR_ERR    = 8'h04;

    // Frame decoder state
    logic [1:0]  state;
    logic [7:0]  opcode;
    logic [2:0]  bytes_left;
    logic [31:0] sr;
    logic [7:0]  hold_data;
    logic        hold_valid;
    logic        err_q;

    // Blink configuration and counter
    logic [31:0] hp_q;
    logic [31:0] cnt;
    logic        enable;
    logic        invert;
    logic        phase;
    logic [8:0]  budget;

    // Byte stream seen by the decoder
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        consume;
    logic        op_known;
    logic [2:0]  op_len;

    logic        exec_period;
    logic        exec_mode;
    logic        exec_blink;
    logic        cfg_commit;

`ifdef SPI_BLINK_TIMEOUT_EN
    logic [31:0] gap;
`else
    // Keeps the parameter list identical in both builds.
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

    // A byte parked in the holding register is older than the live strobe,
    // so it is always presented to the decoder first.
    always_comb begin
        in_valid = hold_valid | o_spi_s_rx_done;
        in_byte  = hold_valid ? hold_data : r_spi_s_rx_data;
        consume  = in_valid && ((state == ST_IDLE) || (state == ST_PAYLOAD));
    end

    always_comb begin
        op_known = 1'b1;
        op_len   = 3'd0;
        case (in_byte)
            OP_NOP:        op_len = 3'd0;
            OP_SET_PERIOD: op_len = 3'd4;
            OP_SET_MODE:   op_len = 3'd1;
            OP_BLINK_N:    op_len = 3'd1;
            OP_CLR_ERR:    op_len = 3'd0;
            default:       op_known = 1'b0;
        endcase
    end

    always_comb begin
        exec_period = (state == ST_EXEC) && (opcode == OP_SET_PERIOD);
        exec_mode   = (state == ST_EXEC) && (opcode == OP_SET_MODE);
        exec_blink  = (state == ST_EXEC) && (opcode == OP_BLINK_N);
        cfg_commit  = exec_period | exec_mode | exec_blink;
    end

    // Holding register: catches a strobe the decoder cannot take this cycle
    // (EXEC), or the live strobe when the held byte is being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            if (consume) begin
                hold_valid <= hold_valid & o_spi_s_rx_done;
            end else begin
                hold_valid <= hold_valid | o_spi_s_rx_done;
            end
            if (o_spi_s_rx_done && (hold_valid || !consume)) begin
                hold_data <= r_spi_s_rx_data;
            end
        end
    end

    // Frame FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            opcode     <= '0;
            bytes_left <= '0;
            sr         <= '0;
            err_q      <= 1'b0;
`ifdef SPI_BLINK_TIMEOUT_EN
            gap        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op_known) begin
                            opcode     <= in_byte;
                            bytes_left <= op_len;
                            sr         <= '0;
                            state      <= (op_len != 3'd0) ? ST_PAYLOAD : ST_EXEC;
`ifdef SPI_BLINK_TIMEOUT_EN
                            gap        <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        sr         <= {sr[23:0], in_byte};
                        bytes_left <= bytes_left - 3'd1;
                        if (bytes_left == 3'd1) begin
                            state <= ST_EXEC;
                        end
`ifdef SPI_BLINK_TIMEOUT_EN
                        gap <= '0;
`endif
                    end
`ifdef SPI_BLINK_TIMEOUT_EN
                    else if (gap == 32'(TIMEOUT_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        err_q <= 1'b1;
                    end else begin
                        gap <= gap + 32'd1;
                    end
`endif
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (opcode == OP_CLR_ERR) begin
                        err_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Blink configuration and toggle counter. A configuration commit takes
    // priority over a wrap in the same cycle: the counter restarts and the
    // phase does not toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_q   <= 32'(DEF_HALF_PERIOD);
            enable <= 1'b1;
            invert <= 1'b0;
            budget <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (cfg_commit) begin
            cnt <= '0;
            if (exec_period) begin
                hp_q <= (sr == 32'd0) ? 32'd1 : sr;
            end
            if (exec_mode) begin
                enable <= sr[0];
                invert <= sr[1];
                if (!sr[0]) begin
                    phase <= 1'b0;
                end
            end
            if (exec_blink) begin
                enable <= 1'b1;
                budget <= {sr[7:0], 1'b0};
            end
        end else if (!enable) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == hp_q - 32'd1) begin
            cnt <= '0;
            if (budget == 9'd1) begin
                // Last budgeted toggle ends the burst at phase 0.
                budget <= '0;
                enable <= 1'b0;
                phase  <= 1'b0;
            end else begin
                phase <= ~phase;
                if (budget != 9'd0) begin
                    budget <= budget - 9'd1;
                end
            end
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign led         = phase ^ invert;
    assign led_en      = 1'b1;
    assign clk_en      = 1'b1;
    assign busy        = (state != ST_IDLE);
    assign err         = err_q;
    assign half_period = hp_q;

endmodule
